button_report_scheduler: RTL and testbench

//  Controller for the per-button press counters of the PS/2 mouse.

---
 rtl/button_report_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_button_report_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_report_scheduler.sv
// button_report_scheduler
//   Takes a snapshot of NUM_BTN 8-bit button press counters, clears them, and
//   sends a report frame on a valid/ready byte stream:
//     HEADER, count[0] .. count[NUM_BTN-1], XOR of all counts.
//   A frame is started by report_req or, when AUTO_EN=1, by a free-running
//   timer that expires every PERIOD cycles. A trigger that arrives during a
//   frame is held in a one-deep pending slot. A trigger that arrives while the
//   slot is already full sets the sticky req_dropped flag.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   report_req   frame request, level sampled every cycle
//   counts       counter values, button i at [8i+7:8i]
//   clear_cnt    one-cycle clear pulse to the counters (cycle after snapshot)
//   tx_data      stream byte
//   tx_valid     tx_data valid
//   tx_ready     sink accepts byte when tx_valid & tx_ready
//   busy         high from snapshot through checksum byte
//   req_dropped  sticky: trigger lost because one was already pending
module button_report_scheduler #(
  parameter int         NUM_BTN = 3,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         PERIOD  = 1000000,
  parameter bit         AUTO_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 report_req,
  input  logic [8*NUM_BTN-1:0] counts,
  output logic [NUM_BTN-1:0]   clear_cnt,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 req_dropped
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_BTN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    HDR,
    DATA,
    CSUM
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   timer;
  logic            timer_hit;
  logic            trig;
  logic [7:0]      snap [NUM_BTN];
  logic [7:0]      csum;
  logic [7:0]      counts_xor;
  logic [IW-1:0]   idx;
  logic            pending;

  // If report_req and timer expiry happen in the same cycle, they form a
  // single trigger.
  assign timer_hit = AUTO_EN && (timer == TIMER_LAST);
  assign trig      = report_req || timer_hit;

  // The timer runs in every state, so the auto-report interval stays fixed
  // no matter how long the stream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // The checksum is computed from the live counts in the same cycle they are
  // snapshotted. The checksum byte therefore always matches the snapshot.
  always_comb begin
    counts_xor = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      counts_xor = counts_xor ^ counts[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stream outputs depend only on state. tx_valid and tx_data therefore stay
  // stable during a stall, and a reset drops them immediately.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = '0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (trig || pending) begin
          state_next = SNAP;
        end
      end
      SNAP: begin
        state_next = HDR;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = snap[idx];
        if (tx_ready && (idx == IDX_LAST)) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The clear pulse is registered, so it reaches the counters one cycle
  // after the sample. A press that lands in the snapshot cycle may be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        snap[i] <= '0;
      end
      csum      <= '0;
      idx       <= '0;
      clear_cnt <= '0;
    end else begin
      clear_cnt <= '0;
      if (state == SNAP) begin
        for (int i = 0; i < NUM_BTN; i++) begin
          snap[i] <= counts[8*i +: 8];
        end
        csum      <= counts_xor;
        idx       <= '0;
        clear_cnt <= '1;
      end else if ((state == DATA) && tx_ready && (idx != IDX_LAST)) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // When the FSM leaves IDLE it consumes the pending slot. A trigger during a
  // frame fills the slot if it is empty; otherwise the trigger is lost and
  // the loss is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      req_dropped <= 1'b0;
    end else if (state == IDLE) begin
      pending <= 1'b0;
    end else if (trig) begin
      if (pending) begin
        req_dropped <= 1'b1;
      end else begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_report_scheduler.sv
// tb_button_report_scheduler
//   Bench for button_report_scheduler. It instantiates two DUTs:
//     dut      - NUM_BTN=3, AUTO_EN=0, driven by vectors and random stimulus
//     dut_auto - NUM_BTN=3, AUTO_EN=1, PERIOD=20, used for periodic frames
module tb_button_report_scheduler;

  localparam int          NB     = 3;
  localparam logic [7:0]  HDRB   = 8'hA5;
  localparam logic [23:0] CNT359 = 24'h090503;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        ready;
  logic [23:0] counts;
  logic [2:0]  clear_cnt;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        dropped;

  logic        a_req;
  logic        a_ready;
  logic [23:0] a_counts;
  logic [2:0]  a_clear;
  logic [7:0]  a_data;
  logic        a_valid;
  logic        a_busy;
  logic        a_dropped;

  int n_checks;
  int n_pass;

  always #5 clk = ~clk;

  assign a_ready = 1'b1;

  button_report_scheduler #(
    .NUM_BTN(NB), .HEADER(HDRB), .PERIOD(1000), .AUTO_EN(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .report_req(req), .counts(counts),
    .clear_cnt(clear_cnt), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready), .busy(busy), .req_dropped(dropped)
  );

  button_report_scheduler #(
    .NUM_BTN(NB), .HEADER(HDRB), .PERIOD(20), .AUTO_EN(1'b1)
  ) dut_auto (
    .clk(clk), .rst(rst), .report_req(a_req), .counts(a_counts),
    .clear_cnt(a_clear), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .busy(a_busy), .req_dropped(a_dropped)
  );

  typedef struct {
    logic        req;
    logic        ready;
    logic [23:0] counts;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_busy;
    logic [2:0]  e_clear;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the bytes of the current frame still to be sent, plus
  // the snapshot-cycle flag, the pending slot and the sticky drop flag
  logic [7:0] m_q[$];
  bit         m_snap;
  bit         m_pending;
  bit         m_dropped;
  bit         m_clear;

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [23:0] c);
    req    = r;
    ready  = rd;
    counts = c;
  endtask

  task automatic checkOutput(input string name, input logic e_valid, input logic [7:0] e_data,
                             input logic e_busy, input logic [2:0] e_clear, input logic e_dropped);
    checkVal({name, ".tx_valid"}, 32'(tx_valid), 32'(e_valid));
    if (e_valid) begin
      checkVal({name, ".tx_data"}, 32'(tx_data), 32'(e_data));
    end
    checkVal({name, ".busy"}, 32'(busy), 32'(e_busy));
    checkVal({name, ".clear_cnt"}, 32'(clear_cnt), 32'(e_clear));
    checkVal({name, ".req_dropped"}, 32'(dropped), 32'(e_dropped));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b1, 24'h0);
    a_req    = 1'b0;
    a_counts = 24'h0;
    rst      = 1'b1;
    tick();
    checkOutput("reset", 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    checkVal("reset.tx_data", 32'(tx_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  function automatic void addVec(input logic r, input logic rd, input logic [23:0] c,
                                 input logic v, input logic [7:0] d, input logic b,
                                 input logic [2:0] cl);
    vec_t x;
    x.req     = r;
    x.ready   = rd;
    x.counts  = c;
    x.e_valid = v;
    x.e_data  = d;
    x.e_busy  = b;
    x.e_clear = cl;
    vecs.push_back(x);
  endfunction

  function automatic void buildVectors();
    // Frame 1: tx_ready held high, bytes in consecutive cycles
    addVec(1'b1, 1'b1, CNT359, 1'b0, 8'h00, 1'b0, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b0, 8'h00, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'hA5, 1'b1, 3'b111);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'h03, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'h05, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'h09, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'h0F, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b0, 8'h00, 1'b0, 3'b000);
    // Frame 2: tx_ready alternates, each byte held through its stall
    addVec(1'b1, 1'b1, CNT359, 1'b0, 8'h00, 1'b0, 3'b000);
    addVec(1'b0, 1'b0, CNT359, 1'b0, 8'h00, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'hA5, 1'b1, 3'b111);
    addVec(1'b0, 1'b0, CNT359, 1'b1, 8'h03, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'h03, 1'b1, 3'b000);
    addVec(1'b0, 1'b0, CNT359, 1'b1, 8'h05, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'h05, 1'b1, 3'b000);
    addVec(1'b0, 1'b0, CNT359, 1'b1, 8'h09, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'h09, 1'b1, 3'b000);
    addVec(1'b0, 1'b0, CNT359, 1'b1, 8'h0F, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b1, 8'h0F, 1'b1, 3'b000);
    addVec(1'b0, 1'b1, CNT359, 1'b0, 8'h00, 1'b0, 3'b000);
  endfunction

  task automatic modelReset();
    m_q.delete();
    m_snap    = 1'b0;
    m_pending = 1'b0;
    m_dropped = 1'b0;
    m_clear   = 1'b0;
  endtask

  task automatic modelCheck(input int cyc);
    bit         e_busy;
    logic [7:0] e_data;
    e_busy = m_snap || (m_q.size() != 0);
    e_data = (m_q.size() != 0) ? m_q[0] : 8'h00;
    checkOutput($sformatf("rand@%0d", cyc), logic'(m_q.size() != 0), e_data, logic'(e_busy),
                m_clear ? 3'b111 : 3'b000, logic'(m_dropped));
  endtask

  // Advance the model by one clock, using the inputs held during this cycle
  task automatic modelStep(input logic r, input logic rd, input logic [23:0] c);
    bit         was_busy;
    bit         was_pending;
    logic [7:0] x;
    was_busy    = m_snap || (m_q.size() != 0);
    was_pending = m_pending;
    m_clear     = m_snap;
    if (m_snap) begin
      x = 8'h00;
      m_q.push_back(HDRB);
      for (int i = 0; i < NB; i++) begin
        m_q.push_back(c[8*i +: 8]);
        x = x ^ c[8*i +: 8];
      end
      m_q.push_back(x);
      m_snap = 1'b0;
    end else if (m_q.size() != 0) begin
      if (rd) begin
        void'(m_q.pop_front());
      end
    end else if (r || m_pending) begin
      m_snap    = 1'b1;
      m_pending = 1'b0;
    end
    if (was_busy && r) begin
      if (was_pending) begin
        m_dropped = 1'b1;
      end else begin
        m_pending = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] frame_359 [5];
    logic [7:0] frame_7 [5];
    int         snaps[$];
    int         first;
    bit         prev_busy;
    logic       r_req;
    logic       r_ready;
    logic [23:0] r_counts;

    frame_359 = '{8'hA5, 8'h03, 8'h05, 8'h09, 8'h0F};
    frame_7   = '{8'hA5, 8'h07, 8'h00, 8'h00, 8'h07};
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    applyStimulus(1'b0, 1'b1, 24'h0);
    a_req    = 1'b0;
    a_counts = 24'h0;

    // Vector table: single frame, then a frame with a stalling sink
    buildVectors();
    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].ready, vecs[i].counts);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                  vecs[i].e_busy, vecs[i].e_clear, 1'b0);
      tick();
    end

    // Two extra requests during a frame: one becomes pending, one is dropped
    doReset();
    applyStimulus(1'b1, 1'b1, CNT359);
    tick();
    applyStimulus(1'b0, 1'b1, CNT359);
    checkOutput("t3.snap", 1'b0, 8'h00, 1'b1, 3'b000, 1'b0);
    tick();
    checkOutput("t3.hdr", 1'b1, 8'hA5, 1'b1, 3'b111, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, CNT359);
    checkOutput("t3.b1", 1'b1, 8'h03, 1'b1, 3'b000, 1'b0);
    tick();
    checkOutput("t3.b2", 1'b1, 8'h05, 1'b1, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, CNT359);
    checkOutput("t3.b3", 1'b1, 8'h09, 1'b1, 3'b000, 1'b1);
    tick();
    checkOutput("t3.csum", 1'b1, 8'h0F, 1'b1, 3'b000, 1'b1);
    tick();
    checkOutput("t3.gap", 1'b0, 8'h00, 1'b0, 3'b000, 1'b1);
    tick();
    checkOutput("t3.snap2", 1'b0, 8'h00, 1'b1, 3'b000, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t3.f2b%0d", k), 1'b1, frame_359[k], 1'b1,
                  (k == 0) ? 3'b111 : 3'b000, 1'b1);
      tick();
    end
    checkOutput("t3.idle1", 1'b0, 8'h00, 1'b0, 3'b000, 1'b1);
    tick();
    checkOutput("t3.idle2", 1'b0, 8'h00, 1'b0, 3'b000, 1'b1);

    // Counts change right after the snapshot; the frame keeps the old value
    doReset();
    applyStimulus(1'b1, 1'b1, 24'h000007);
    tick();
    applyStimulus(1'b0, 1'b1, 24'h000007);
    tick();
    applyStimulus(1'b0, 1'b1, 24'h000008);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t5.b%0d", k), 1'b1, frame_7[k], 1'b1,
                  (k == 0) ? 3'b111 : 3'b000, 1'b0);
      tick();
    end
    checkOutput("t5.end", 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);

    // Reset in DATA with idx=1 and a request pending: abort, then stay idle
    doReset();
    applyStimulus(1'b1, 1'b1, CNT359);
    tick();
    applyStimulus(1'b0, 1'b1, CNT359);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, CNT359);
    tick();
    applyStimulus(1'b0, 1'b1, CNT359);
    checkOutput("t6.idx1", 1'b1, 8'h05, 1'b1, 3'b000, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6.abort", 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("t6.wait%0d", k), 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      tick();
    end

    // Periodic frames on the auto DUT; one request coincides with expiry
    doReset();
    a_counts  = 24'h030201;
    first     = -1;
    prev_busy = 1'b0;
    for (int c = 0; c < 75; c++) begin
      if (a_busy && !prev_busy) begin
        snaps.push_back(c);
        if (first < 0) begin
          first = c;
        end
      end
      prev_busy = a_busy;
      a_req = (first >= 0) && (c == first + 19);
      tick();
    end
    a_req = 1'b0;
    checkVal("auto.frame_count", 32'(snaps.size()), 32'd3);
    for (int k = 1; k < snaps.size(); k++) begin
      checkVal($sformatf("auto.interval%0d", k), 32'(snaps[k] - snaps[k-1]), 32'd20);
    end
    checkVal("auto.req_dropped", 32'(a_dropped), 32'd0);

    // Random requests, sink stalls and counts against the frame model
    doReset();
    modelReset();
    for (int c = 0; c < 600; c++) begin
      r_req    = ($urandom_range(0, 7) == 0);
      r_ready  = ($urandom_range(0, 3) != 0);
      r_counts = 24'($urandom);
      applyStimulus(r_req, r_ready, r_counts);
      modelCheck(c);
      modelStep(r_req, r_ready, r_counts);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
